// File: rtl/sr_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_ctrl
// Brief    : Debounced on/off request controller issuing single-cycle set and
//            reset pulses to a reset-less downstream SR flop, with hold-off.
// Revision : 1.0
// ============================================================================
module sr_pulse_ctrl #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic on_req,
  input  logic off_req,
  output logic set,
  output logic reset,
  output logic busy,
  output logic state_on,
  output logic conflict
);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_OFF      = 3'd1,
    S_ON_WAIT  = 3'd2,
    S_ON       = 3'd3,
    S_OFF_WAIT = 3'd4
  } state_t;

  localparam logic [7:0] c_deb  = 8'(DEB_CYCLES);
  localparam logic [7:0] c_hold = 8'(HOLD_CYCLES);

  logic [1:0] w_req;
  logic [1:0] w_rise;

  assign w_req = {off_req, on_req};

  // Index 0 carries on_req, index 1 carries off_req.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      logic       r_sync1;
      logic       r_sync2;
      logic       r_deb;
      logic       r_deb_prev;
      logic [7:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_deb      <= 1'b0;
          r_deb_prev <= 1'b0;
          r_cnt      <= 8'd0;
        end else begin
          r_sync1    <= w_req[gi];
          r_sync2    <= r_sync1;
          r_deb_prev <= r_deb;
          if (r_sync2 == r_deb) begin
            r_cnt <= 8'd0;
          end else if (r_cnt == c_deb - 8'd1) begin
            r_deb <= ~r_deb;
            r_cnt <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end

      assign w_rise[gi] = r_deb & ~r_deb_prev;
    end
  endgenerate

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_timer;
  logic [7:0] w_timer_next;
  logic       w_set_next;
  logic       w_reset_next;
  logic       w_conflict_next;
  logic       w_busy_next;
  logic       w_on_next;

  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_set_next      = 1'b0;
    w_reset_next    = 1'b0;
    w_conflict_next = 1'b0;
    case (r_state)
      // Downstream flop has no reset, so force it to a known 0 first.
      S_INIT: begin
        w_reset_next = 1'b1;
        w_timer_next = c_hold;
        w_state_next = S_OFF_WAIT;
      end
      S_OFF: begin
        if (w_rise[0] && w_rise[1]) begin
          w_conflict_next = 1'b1;
        end else if (w_rise[0]) begin
          w_set_next   = 1'b1;
          w_timer_next = c_hold;
          w_state_next = S_ON_WAIT;
        end
      end
      S_ON: begin
        if (w_rise[0] && w_rise[1]) begin
          w_conflict_next = 1'b1;
        end else if (w_rise[1]) begin
          w_reset_next = 1'b1;
          w_timer_next = c_hold;
          w_state_next = S_OFF_WAIT;
        end
      end
      S_ON_WAIT: begin
        if (r_timer <= 8'd1) begin
          w_timer_next = 8'd0;
          w_state_next = S_ON;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      S_OFF_WAIT: begin
        if (r_timer <= 8'd1) begin
          w_timer_next = 8'd0;
          w_state_next = S_OFF;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      default: begin
        w_state_next = S_INIT;
        w_timer_next = 8'd0;
      end
    endcase
    // Status flags are registered from the next state so they align with it.
    w_busy_next = (w_state_next == S_INIT) || (w_state_next == S_ON_WAIT) ||
                  (w_state_next == S_OFF_WAIT);
    w_on_next   = (w_state_next == S_ON_WAIT) || (w_state_next == S_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_INIT;
      r_timer  <= 8'd0;
      set      <= 1'b0;
      reset    <= 1'b0;
      conflict <= 1'b0;
      busy     <= 1'b0;
      state_on <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      set      <= w_set_next;
      reset    <= w_reset_next;
      conflict <= w_conflict_next;
      busy     <= w_busy_next;
      state_on <= w_on_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_ctrl.sv
`default_nettype none
// Testbench for sr_pulse_ctrl: directed scenarios plus random request traffic,
// every cycle compared against a behavioural model of the request rules.
module tb_sr_pulse_ctrl;

  localparam int c_deb  = 4;
  localparam int c_hold = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic on_req = 1'b0;
  logic off_req = 1'b0;
  logic set, reset, busy, state_on, conflict;

  int n_checks = 0;
  int n_pass   = 0;

  sr_pulse_ctrl #(.DEB_CYCLES(c_deb), .HOLD_CYCLES(c_hold)) dut (
    .clk(clk), .rst(rst), .on_req(on_req), .off_req(off_req),
    .set(set), .reset(reset), .busy(busy), .state_on(state_on),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: synchronizer as a two-deep sample history, debounce as
  // a run-length of disagreeing samples, command FSM as "commanded value plus
  // remaining hold cycles".
  bit m_hist1[2], m_hist2[2], m_deb[2], m_prev[2];
  int m_run[2];
  bit m_init, m_on;
  int m_hold;
  bit e_set, e_reset, e_conf, e_busy, e_on;

  task automatic model_step();
    bit rise[2];
    bit in_v[2];
    in_v[0] = on_req;
    in_v[1] = off_req;
    e_set = 0; e_reset = 0; e_conf = 0;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_hist1[i] = 0; m_hist2[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_run[i] = 0;
      end
      m_init = 1; m_on = 0; m_hold = 0; e_busy = 0; e_on = 0;
      return;
    end
    for (int i = 0; i < 2; i++) rise[i] = m_deb[i] && !m_prev[i];
    if (m_init) begin
      e_reset = 1; m_on = 0; m_hold = c_hold; m_init = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (rise[0] && rise[1]) begin
      e_conf = 1;
    end else if (rise[0] && !m_on) begin
      e_set = 1; m_on = 1; m_hold = c_hold;
    end else if (rise[1] && m_on) begin
      e_reset = 1; m_on = 0; m_hold = c_hold;
    end
    e_busy = (m_hold > 0);
    e_on   = m_on;
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = m_deb[i];
      if (m_hist2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == c_deb) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_hist2[i] = m_hist1[i];
      m_hist1[i] = in_v[i];
    end
  endtask

  task automatic tick(input bit r, input bit a, input bit b);
    @(negedge clk);
    rst = r; on_req = a; off_req = b;
    @(posedge clk);
    model_step();
    #1;
    chk("set", set, e_set);
    chk("reset", reset, e_reset);
    chk("conflict", conflict, e_conf);
    chk("busy", busy, e_busy);
    chk("state_on", state_on, e_on);
    chk("set_and_reset", set & reset, 0);
  endtask

  task automatic hold_in(input bit r, input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) tick(r, a, b);
  endtask

  int lat;
  int saw_conf;

  initial begin
    // Reset, then release: INIT reset pulse and one hold window.
    hold_in(1, 0, 0, 3);
    hold_in(0, 0, 0, 12);
    chk("idle_off_busy", busy, 0);

    // on_req held high: set latency from the first sampling edge.
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      tick(0, 1, 0);
      if (set && lat < 0) lat = j;
    end
    chk("set_latency", lat, c_deb + 2);
    chk("on_after_set", state_on, 1);
    hold_in(0, 0, 0, 10);

    // Short glitch must not register.
    hold_in(0, 1, 0, 3);
    hold_in(0, 0, 0, 10);

    // Turn off, then back on; off edge inside the hold window is dropped.
    hold_in(0, 0, 1, 8);
    hold_in(0, 0, 0, 15);
    chk("off_again", state_on, 0);
    hold_in(0, 1, 0, 7);
    hold_in(0, 1, 1, 6);
    hold_in(0, 1, 0, 12);
    chk("dropped_off", state_on, 1);
    hold_in(0, 1, 1, 8);
    hold_in(0, 0, 0, 15);
    chk("second_off", state_on, 0);

    // Coincident on/off edges in OFF produce a conflict.
    saw_conf = 0;
    for (int j = 0; j < 10; j++) begin
      tick(0, 1, 1);
      if (conflict) saw_conf++;
    end
    chk("conflict_seen", saw_conf, 1);
    chk("conflict_state", state_on, 0);
    hold_in(0, 0, 0, 10);

    // Reset pulse in the middle of ON_WAIT.
    hold_in(0, 1, 0, 10);
    hold_in(1, 1, 0, 1);
    chk("mid_rst_on", state_on, 0);
    hold_in(0, 1, 0, 25);
    hold_in(0, 0, 0, 12);

    // Random request traffic with occasional reset.
    for (int s = 0; s < 300; s++) begin
      bit r, a, b;
      int n;
      r = ($urandom_range(0, 39) == 0);
      a = $urandom_range(0, 1);
      b = ($urandom_range(0, 3) == 0) ? a : 1'($urandom_range(0, 1));
      n = r ? 1 : $urandom_range(1, 12);
      hold_in(r, a, b, n);
    end
    hold_in(0, 0, 0, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
